// File: rtl/muxn_lanes.sv
// N-lane to 1 byte-interleaving multiplexer: per-lane FIFOs drained round-robin (strict slot or work-conserving).
// Define MUXN_OVF_EN to add the sticky per-lane overflow output for bytes dropped at a full FIFO.
module muxn_lanes #(
    parameter int LANES      = 4,
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int SKIP_EMPTY = 0
) (
    input  logic                       clk_4f,
    input  logic                       reset,
    input  logic [LANES-1:0]           validEntrada,
    input  logic [LANES*WIDTH-1:0]     Entrada,
    output logic [LANES-1:0]           ready,
    output logic [WIDTH-1:0]           Salida,
    output logic                       validsalida,
    output logic [$clog2(LANES)-1:0]   lane_sel
`ifdef MUXN_OVF_EN
    ,
    output logic [LANES-1:0]           overflow
`endif
);

    localparam int SW = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [LANES-1:0]            nonempty;
    logic [LANES-1:0]            pop;
    logic [LANES-1:0][WIDTH-1:0] head;
    logic [SW-1:0]               ptr_reg;
    logic [SW-1:0]               pick;
    logic                        found;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH-1:0] mem [DEPTH];
            logic [AW-1:0]    wr_ptr_reg;
            logic [AW-1:0]    rd_ptr_reg;
            logic [CW-1:0]    count_reg;
            logic             push;

            // ready comes only from the registered count, so a full lane stays blocked even while it pops
            assign ready[gi]    = reset && (count_reg != CW'(DEPTH));
            assign push         = validEntrada[gi] && ready[gi];
            assign nonempty[gi] = (count_reg != '0);
            assign head[gi]     = mem[rd_ptr_reg];

            always_ff @(posedge clk_4f) begin
                if (push) begin
                    mem[wr_ptr_reg] <= Entrada[gi*WIDTH +: WIDTH];
                end
            end

            always_ff @(posedge clk_4f or negedge reset) begin
                if (!reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    end
                    if (push && !pop[gi]) begin
                        count_reg <= count_reg + CW'(1);
                    end else if (!push && pop[gi]) begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        pick  = ptr_reg;
        pop   = '0;
        if (SKIP_EMPTY == 0) begin
            found = nonempty[ptr_reg];
        end else begin
            // Scan downwards so the lane closest to ptr wins
            for (int j = LANES - 1; j >= 0; j--) begin
                if (nonempty[ptr_reg + SW'(j)]) begin
                    found = 1'b1;
                    pick  = ptr_reg + SW'(j);
                end
            end
        end
        if (found) begin
            pop[pick] = 1'b1;
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            ptr_reg     <= '0;
            lane_sel    <= '0;
            Salida      <= '0;
            validsalida <= 1'b0;
        end else begin
            validsalida <= found;
            Salida      <= found ? head[pick] : '0;
            if (SKIP_EMPTY == 0) begin
                lane_sel <= ptr_reg;
                ptr_reg  <= ptr_reg + SW'(1);
            end else if (found) begin
                lane_sel <= pick;
                ptr_reg  <= pick + SW'(1);
            end
        end
    end

`ifdef MUXN_OVF_EN
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            overflow <= '0;
        end else begin
            overflow <= overflow | (validEntrada & ~ready);
        end
    end
`endif

endmodule
